// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the multicore data-memory arbiter: FSM encodings
// and default bus widths.
package dmem_arbiter_pkg;

    localparam int ARB_STATE_W = 2;
    localparam int ARB_ADDR_W  = 32;
    localparam int ARB_DATA_W  = 32;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Shared data-memory port: req/ready handshake with variable latency.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) ();

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Round-robin winner selection: rotate the request vector so the search
// starts just after last_grant, then take the lowest set bit.
module rr_picker #(
    parameter int NUM_CORES = 4,
    parameter int GNT_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [GNT_W-1:0]     last_grant,
    output logic [GNT_W-1:0]     winner,
    output logic                 any_req
);

    localparam int unsigned N = NUM_CORES;

    logic [NUM_CORES-1:0] rot;
    int unsigned          start;
    int unsigned          offset;
    int unsigned          idx;

    always_comb begin
        start = 32'(last_grant) + 1;
        if (start >= N) start = 0;
        rot = NUM_CORES'({req, req} >> start);
        offset = 0;
        // Scan downward so the lowest set bit is the one left in offset
        for (int unsigned i = N; i > 0; i--) begin
            if (rot[i-1]) offset = i - 1;
        end
        idx = start + offset;
        if (idx >= N) idx = idx - N;
        winner  = GNT_W'(idx);
        any_req = |req;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises NUM_CORES dmem ports onto one shared memory port with
// round-robin arbitration, stalling each core until its access completes.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int GNT_W     = $clog2(NUM_CORES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          core_read_en,
    input  logic [NUM_CORES-1:0]          core_write_en,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [NUM_CORES*DATA_W-1:0]   core_rdata,
    output logic [NUM_CORES-1:0]          core_stall,
    dmem_arbiter_if.master                mem,
    output logic [GNT_W-1:0]              grant_id,
    output logic                          busy
);

    arb_state_e                       state;
    logic [NUM_CORES-1:0]             req;
    logic [GNT_W-1:0]                 winner;
    logic                             any_req;
    logic [GNT_W-1:0]                 last_grant;
    logic [GNT_W-1:0]                 grant_q;
    logic                             we_q;
    logic [ADDR_W-1:0]                addr_q;
    logic [DATA_W-1:0]                wdata_q;
    logic                             mem_req_q;
    logic                             busy_q;
    logic [NUM_CORES-1:0][DATA_W-1:0] rdata_q;

    assign req = core_read_en | core_write_en;

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .GNT_W     (GNT_W)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            last_grant <= GNT_W'(NUM_CORES - 1);
            grant_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_q    <= winner;
                        last_grant <= winner;
                        // Read+write together is resolved as a write
                        we_q       <= core_write_en[winner];
                        addr_q     <= core_addr[winner*ADDR_W +: ADDR_W];
                        wdata_q    <= core_wdata[winner*DATA_W +: DATA_W];
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mem.mem_ready) begin
                        if (!we_q) rdata_q[grant_q] <= mem.mem_rdata;
                        mem_req_q <= 1'b0;
                        state     <= ARB_DONE;
                    end
                end
                ARB_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ARB_IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state     <= ARB_IDLE;
                end
            endcase
        end
    end

    // Only the granted core is released, and only during DONE
    always_comb begin
        core_stall = req;
        if (state == ARB_DONE) core_stall[grant_q] = 1'b0;
    end

    assign core_rdata    = rdata_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with four cores.
module tb_dmem_arbiter;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int GW = 2;

    logic              clk;
    logic              rst;
    logic [NC-1:0]     core_read_en;
    logic [NC-1:0]     core_write_en;
    logic [NC*AW-1:0]  core_addr;
    logic [NC*DW-1:0]  core_wdata;
    logic [NC*DW-1:0]  core_rdata;
    logic [NC-1:0]     core_stall;
    logic [GW-1:0]     grant_id;
    logic              busy;

    int n_cmp;
    int n_err;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

    dmem_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .GNT_W     (GW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_read_en  (core_read_en),
        .core_write_en (core_write_en),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .mem           (mif.master),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] lane(input logic [NC*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        core_read_en = '0;
        core_write_en = '0;
        core_addr = '0;
        core_wdata = '0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;

        // Reset state
        #2;
        check("rst_mem_req", 64'(mif.mem_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_addr", 64'(mif.mem_addr), 64'd0);
        check("rst_we", 64'(mif.mem_we), 64'd0);
        check("rst_rdata_lo", core_rdata[63:0], 64'd0);
        check("rst_rdata_hi", core_rdata[127:64], 64'd0);
        rst = 1'b1;

        // Single read from core 2
        core_read_en = 4'b0100;
        core_addr[2*AW +: AW] = 32'h100;
        #1;
        check("rd_stall_c0", 64'(core_stall), 64'h4);
        tick();
        check("rd_mem_req", 64'(mif.mem_req), 64'd1);
        check("rd_mem_addr", 64'(mif.mem_addr), 64'h100);
        check("rd_mem_we", 64'(mif.mem_we), 64'd0);
        check("rd_grant", 64'(grant_id), 64'd2);
        check("rd_busy", 64'(busy), 64'd1);
        check("rd_stall_c1", 64'(core_stall), 64'h4);
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 32'hDEADBEEF;
        tick();
        check("rd_stall_c2", 64'(core_stall), 64'h0);
        check("rd_mem_req_done", 64'(mif.mem_req), 64'd0);
        check("rd_lane2", 64'(lane(core_rdata, 2)), 64'hDEADBEEF);
        check("rd_lane0", 64'(lane(core_rdata, 0)), 64'd0);
        check("rd_lane1", 64'(lane(core_rdata, 1)), 64'd0);
        check("rd_lane3", 64'(lane(core_rdata, 3)), 64'd0);
        core_read_en = '0;
        mif.mem_ready = 1'b0;
        tick();
        check("rd_idle_busy", 64'(busy), 64'd0);

        // Stray ready while idle
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 32'h55555555;
        tick();
        tick();
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_mem_req", 64'(mif.mem_req), 64'd0);
        check("stray_lane2", 64'(lane(core_rdata, 2)), 64'hDEADBEEF);
        check("stray_lo", 64'(core_rdata[63:0]), 64'd0);
        mif.mem_ready = 1'b0;

        // Read+write together on core 3 behaves as a write
        core_read_en = 4'b1000;
        core_write_en = 4'b1000;
        core_addr[3*AW +: AW] = 32'h40;
        core_wdata[3*DW +: DW] = 32'h12345678;
        tick();
        check("rw_grant", 64'(grant_id), 64'd3);
        check("rw_we", 64'(mif.mem_we), 64'd1);
        check("rw_addr", 64'(mif.mem_addr), 64'h40);
        check("rw_wdata", 64'(mif.mem_wdata), 64'h12345678);
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 32'hFFFF0000;
        tick();
        check("rw_stall", 64'(core_stall), 64'h0);
        check("rw_lane3", 64'(lane(core_rdata, 3)), 64'd0);
        core_read_en = '0;
        core_write_en = '0;
        mif.mem_ready = 1'b0;
        tick();

        // Core 1 read with five wait states
        core_read_en = 4'b0010;
        core_addr[1*AW +: AW] = 32'h200;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("ws_addr", 64'(mif.mem_addr), 64'h200);
            check("ws_we", 64'(mif.mem_we), 64'd0);
            check("ws_req", 64'(mif.mem_req), 64'd1);
            check("ws_stall", 64'(core_stall), 64'h2);
            tick();
        end
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 32'hCAFEF00D;
        check("ws_addr_last", 64'(mif.mem_addr), 64'h200);
        check("ws_stall_last", 64'(core_stall), 64'h2);
        tick();
        check("ws_stall_done", 64'(core_stall), 64'h0);
        check("ws_lane1", 64'(lane(core_rdata, 1)), 64'hCAFEF00D);
        core_read_en = '0;
        mif.mem_ready = 1'b0;
        tick();

        // Reset during core 0's access
        core_read_en = 4'b0001;
        core_addr[0 +: AW] = 32'h300;
        tick();
        check("mr_grant", 64'(grant_id), 64'd0);
        check("mr_req_before", 64'(mif.mem_req), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mr_req_now", 64'(mif.mem_req), 64'd0);
        check("mr_busy_now", 64'(busy), 64'd0);
        check("mr_lane1_clr", 64'(lane(core_rdata, 1)), 64'd0);
        check("mr_stall", 64'(core_stall), 64'h1);
        tick();
        rst = 1'b1;
        tick();
        check("mr_regrant", 64'(grant_id), 64'd0);
        check("mr_readdr", 64'(mif.mem_addr), 64'h300);
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 32'h0BADC0DE;
        tick();
        check("mr_stall_done", 64'(core_stall), 64'h0);
        check("mr_lane0", 64'(lane(core_rdata, 0)), 64'h0BADC0DE);
        core_read_en = '0;
        mif.mem_ready = 1'b0;
        tick();

        // Contention from a clean reset: all four cores write continuously
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < NC; i++) begin
            core_addr[i*AW +: AW] = 32'h1000 + 32'(i * 4);
            core_wdata[i*DW +: DW] = 32'hC0DE0000 | 32'(i);
        end
        core_write_en = 4'hF;
        mif.mem_ready = 1'b1;
        mif.mem_rdata = 32'h77777777;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("ct_grant", 64'(grant_id), 64'(k % NC));
            check("ct_we", 64'(mif.mem_we), 64'd1);
            check("ct_wdata", 64'(mif.mem_wdata), 64'(32'hC0DE0000 | 32'(k % NC)));
            check("ct_addr", 64'(mif.mem_addr), 64'(32'h1000 + 32'((k % NC) * 4)));
            check("ct_stall_busy", 64'(core_stall), 64'hF);
            tick();
            check("ct_stall_done", 64'(core_stall), 64'(4'hF & ~(4'b0001 << (k % NC))));
            tick();
            check("ct_stall_idle", 64'(core_stall), 64'hF);
        end
        check("ct_rdata_lo", core_rdata[63:0], 64'd0);
        check("ct_rdata_hi", core_rdata[127:64], 64'd0);
        core_write_en = '0;
        mif.mem_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one data-memory port between NUM_CORES pipelined RISC-V cores in the multicore build.
- Sits between each core's dmem_* interface and the single shared data memory.
- Arbitrates with a round-robin scheme, serialises accesses, and stalls each core until its access completes.
- Memory side uses a req/ready handshake with variable latency.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
GNT_W, $clog2(NUM_CORES), grant index width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
core_read_en  input  NUM_CORES  per-core load request
core_write_en  input  NUM_CORES  per-core store request
core_addr  input  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W]
core_wdata  input  NUM_CORES*DATA_W  per-core store data, same packing
core_rdata  output  NUM_CORES*DATA_W  per-core registered load data
core_stall  output  NUM_CORES  per-core freeze request, combinational
mem_req  output  1  shared-memory request valid
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  latched request address
mem_wdata  output  DATA_W  latched store data
mem_ready  input  1  memory accepted/completed the access this cycle
mem_rdata  input  DATA_W  read data, valid when mem_ready=1 and mem_we=0
grant_id  output  GNT_W  index of the core currently owning the port
busy  output  1  FSM not in IDLE

Behaviour:
- req[i] = core_read_en[i] | core_write_en[i]. If both are set, the access is treated as a write (protocol error, not flagged).
- FSM states (encoded 2 bits): IDLE=0, BUSY=1, DONE=2.
  - IDLE:
    - If any req, pick the winner by round robin, searching from last_grant+1 upward with wrap at NUM_CORES.
    - Latch grant_id, we, addr and wdata from the winner; set last_grant <= winner; go to BUSY.
    - With no req, stay in IDLE.
  - BUSY:
    - mem_req=1; mem_we, mem_addr, mem_wdata are held stable from the latch.
    - On mem_ready: if a read, core_rdata[grant_id] <= mem_rdata; go to DONE.
    - Otherwise stay in BUSY, with no timeout.
  - DONE: one cycle; mem_req=0; go to IDLE unconditionally. A new arbitration starts in the following IDLE cycle.
- core_stall[i] = req[i] & ~(state==DONE & grant_id==i).
  - Stall is asserted in the same cycle the request appears.
  - The granted core sees stall low in exactly one cycle (DONE), with its load data already registered.
- Minimum latency with mem_ready tied high: request in cycle 0 (IDLE), BUSY in cycle 1, DONE in cycle 2. Stall is high in cycles 0-1 and low in cycle 2.
- A request dropped while not granted is simply ignored. A granted request cannot be withdrawn: the transaction always completes.
- mem_ready seen outside BUSY is ignored.
- Writes never modify core_rdata. Each core_rdata lane holds its value until that core's next completed read.
- Fairness: with all cores requesting continuously, the grant order is 0,1,...,N-1,0,... and each core waits at most (NUM_CORES-1) transactions.
- Reset (rst=0, asynchronous), applied immediately, including mid-transaction:
  - state=IDLE; last_grant=NUM_CORES-1, so core 0 wins first.
  - grant_id=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all core_rdata=0, busy=0.
  - core_stall follows req combinationally.
  - An aborted memory access is abandoned; the memory must tolerate mem_req dropping.
- Reset release is synchronous to clk. The first arbitration happens on the first rising edge with rst=1.

Decomposition:
- Shared package/header holds the state encodings (ARB_IDLE, ARB_BUSY, ARB_DONE), ARB_STATE_W=2, and the default ADDR_W/DATA_W. The core and the top level include the same header.
- One combinational sub-module, rr_picker(NUM_CORES):
  - Inputs: req vector, last_grant.
  - Outputs: winner index and any_req.
  - Implemented as a double-width rotate plus priority encode.
- The FSM, latches and rdata registers stay in dmem_arbiter.

Test Plan:
- Single read: core 2 read_en, addr 0x100; mem_ready high in cycle 1 with rdata 0xDEADBEEF. Required: mem_req=1 and mem_addr=0x100 in cycle 1; core_stall[2]=0 in cycle 2; core_rdata[2]=0xDEADBEEF; other lanes 0.
- Contention: all 4 cores write simultaneously and stay asserted. Required: grant order 0,1,2,3,0; each core's mem_wdata matches its core_wdata; each stall drops for exactly one cycle.
- Memory wait states: core 1 read; mem_ready held low 5 cycles, then high. Required: mem_addr/mem_we stable across all 6 BUSY cycles; core_stall[1] high until DONE.
- Read+write both set on core 3, addr 0x40, wdata 0x12345678. Required: mem_we=1; core_rdata[3] unchanged.
- Reset mid-BUSY: assert rst=0 between edges during core 0's access. Required: mem_req=0 and busy=0 immediately; after release, core 0 wins first and the re-issued request completes normally.
- Idle/stray ready: no requests; pulse mem_ready. Required: state stays IDLE, mem_req=0, all core_rdata unchanged.
